// File: rtl/s32x_sdr_arb.sv
// s32x_sdr_arb: three-way arbiter/sequencer for the 32X 16-bit SDRAM port.
// Define S32X_SDR_ARB_RR_EN for round-robin; otherwise fixed priority 0>1>2.
module s32x_sdr_arb #(
    parameter bit          USE_SDR_WAIT = 1'b0,
    parameter int unsigned LAT          = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  REQ,
    input  logic [1:0]  WE0,
    input  logic [1:0]  WE1,
    input  logic [1:0]  WE2,
    input  logic [16:0] A0,
    input  logic [16:0] A1,
    input  logic [16:0] A2,
    input  logic [15:0] DO0,
    input  logic [15:0] DO1,
    input  logic [15:0] DO2,
    output logic [15:0] DI0,
    output logic [15:0] DI1,
    output logic [15:0] DI2,
    output logic [2:0]  ACK,
    output logic [2:0]  GNT,
    output logic        BUSY,
    output logic [16:0] SDR_A,
    output logic [15:0] SDR_DO,
    output logic        SDR_CS,
    output logic [1:0]  SDR_WE,
    output logic        SDR_RD,
    input  logic [15:0] SDR_DI,
    input  logic        SDR_WAIT
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t      state, state_nx;
    logic [1:0]  sel;
    logic [1:0]  cur;
    logic [2:0]  cnt;
    logic        first;
    logic        done;
    logic        hit;
    logic [16:0] a_s;
    logic [15:0] d_s;
    logic [1:0]  w_s;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef S32X_SDR_ARB_RR_EN
    logic [1:0] ptr;
    logic [1:0] c1, c2;

    always_comb begin
        c1 = nxt(ptr);
        c2 = nxt(c1);
        if (REQ[ptr])     sel = ptr;
        else if (REQ[c1]) sel = c1;
        else              sel = c2;
    end
`else
    always_comb begin
        if (REQ[0])      sel = 2'd0;
        else if (REQ[1]) sel = 2'd1;
        else             sel = 2'd2;
    end
`endif

    always_comb begin
        case (sel)
            2'd1:    begin a_s = A1; d_s = DO1; w_s = WE1; end
            2'd2:    begin a_s = A2; d_s = DO2; w_s = WE2; end
            default: begin a_s = A0; d_s = DO0; w_s = WE0; end
        endcase
    end

    assign hit  = |REQ;
    assign BUSY = (state != IDLE);
    // WAIT is ignored in the first ACCESS cycle so the controller can react to CS
    assign done = USE_SDR_WAIT ? (!first && !SDR_WAIT) : (cnt == 3'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hit)  state_nx = ACCESS;
            ACCESS:  if (done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            GNT    <= 3'b000;
            ACK    <= 3'b000;
            SDR_A  <= '0;
            SDR_DO <= '0;
            SDR_WE <= 2'b00;
            SDR_CS <= 1'b0;
            SDR_RD <= 1'b0;
            DI0    <= '0;
            DI1    <= '0;
            DI2    <= '0;
            cur    <= 2'd0;
            cnt    <= 3'd0;
            first  <= 1'b0;
`ifdef S32X_SDR_ARB_RR_EN
            ptr    <= 2'd0;
`endif
        end else begin
            ACK <= 3'b000;
            unique case (state)
                IDLE: if (hit) begin
                    GNT    <= 3'b001 << sel;
                    cur    <= sel;
                    SDR_A  <= a_s;
                    SDR_DO <= d_s;
                    SDR_WE <= w_s;
                    SDR_CS <= 1'b1;
                    SDR_RD <= ~|w_s;
                    cnt    <= CNT_INIT;
                    first  <= 1'b1;
                end
                ACCESS: begin
                    first <= 1'b0;
                    if (done) begin
                        if (SDR_RD) begin
                            case (cur)
                                2'd0:    DI0 <= SDR_DI;
                                2'd1:    DI1 <= SDR_DI;
                                default: DI2 <= SDR_DI;
                            endcase
                        end
                        ACK    <= GNT;
                        SDR_CS <= 1'b0;
                        SDR_RD <= 1'b0;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    GNT <= 3'b000;
`ifdef S32X_SDR_ARB_RR_EN
                    ptr <= nxt(cur);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s32x_sdr_arb.sv
// tb_s32x_sdr_arb: directed bench for s32x_sdr_arb.
// Instance u_dut counts LAT=2 cycles; u_dw takes completion from SDR_WAIT.
module tb_s32x_sdr_arb;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [2:0]  REQ = '0;
    logic [1:0]  WE0 = '0, WE1 = '0, WE2 = '0;
    logic [16:0] A0 = '0, A1 = '0, A2 = '0;
    logic [15:0] DO0 = '0, DO1 = '0, DO2 = '0;
    logic [15:0] SDR_DI = '0;
    logic        SDR_WAIT = 1'b0;

    logic [15:0] di0, di1, di2;
    logic [2:0]  ack, gnt;
    logic        busy, sdr_cs, sdr_rd;
    logic [16:0] sdr_a;
    logic [15:0] sdr_do;
    logic [1:0]  sdr_we;

    logic [15:0] w_di0, w_di1, w_di2;
    logic [2:0]  w_ack, w_gnt;
    logic        w_busy, w_cs, w_rd;
    logic [16:0] w_a;
    logic [15:0] w_do;
    logic [1:0]  w_we;

    int n_chk = 0;
    int n_bad = 0;
    int exp_ord [4];

    always #5 CLK = ~CLK;

    s32x_sdr_arb #(.USE_SDR_WAIT(1'b0), .LAT(2)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .WE0(WE0), .WE1(WE1), .WE2(WE2),
        .A0(A0), .A1(A1), .A2(A2),
        .DO0(DO0), .DO1(DO1), .DO2(DO2),
        .DI0(di0), .DI1(di1), .DI2(di2),
        .ACK(ack), .GNT(gnt), .BUSY(busy),
        .SDR_A(sdr_a), .SDR_DO(sdr_do), .SDR_CS(sdr_cs),
        .SDR_WE(sdr_we), .SDR_RD(sdr_rd),
        .SDR_DI(SDR_DI), .SDR_WAIT(SDR_WAIT)
    );

    s32x_sdr_arb #(.USE_SDR_WAIT(1'b1), .LAT(2)) u_dw (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .WE0(WE0), .WE1(WE1), .WE2(WE2),
        .A0(A0), .A1(A1), .A2(A2),
        .DO0(DO0), .DO1(DO1), .DO2(DO2),
        .DI0(w_di0), .DI1(w_di1), .DI2(w_di2),
        .ACK(w_ack), .GNT(w_gnt), .BUSY(w_busy),
        .SDR_A(w_a), .SDR_DO(w_do), .SDR_CS(w_cs),
        .SDR_WE(w_we), .SDR_RD(w_rd),
        .SDR_DI(SDR_DI), .SDR_WAIT(SDR_WAIT)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
`ifdef S32X_SDR_ARB_RR_EN
        exp_ord = '{0, 1, 2, 0};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        // reset values
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cs", 32'(sdr_cs), 0);
        chk("rst_rd", 32'(sdr_rd), 0);
        chk("rst_we", 32'(sdr_we), 0);
        chk("rst_a", 32'(sdr_a), 0);
        chk("rst_do", 32'(sdr_do), 0);
        chk("rst_di", 32'({di0, di1} | 32'(di2)), 0);
        tick();
        RST_N = 1'b1;

        // master SH2 read
        A0 = 17'h00100;
        SDR_DI = 16'hBEEF;
        REQ = 3'b001;
        tick();
        chk("rd_cs", 32'(sdr_cs), 1);
        chk("rd_rd", 32'(sdr_rd), 1);
        chk("rd_gnt", 32'(gnt), 32'b001);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_a", 32'(sdr_a), 32'h00100);
        tick();
        chk("rd_ack_early", 32'(ack), 0);
        tick();
        chk("rd_ack", 32'(ack), 32'b001);
        chk("rd_di0", 32'(di0), 32'hBEEF);
        chk("rd_cs_off", 32'(sdr_cs), 0);
        REQ = 3'b000;
        tick();
        chk("rd_ack_pulse", 32'(ack), 0);
        chk("rd_gnt_clr", 32'(gnt), 0);
        chk("rd_idle", 32'(busy), 0);

        // slave SH2 write
        WE1 = 2'b10;
        DO1 = 16'h1234;
        A1 = 17'h1FFFF;
        SDR_DI = 16'h5555;
        REQ = 3'b010;
        tick();
        chk("wr_we", 32'(sdr_we), 32'b10);
        chk("wr_do", 32'(sdr_do), 32'h1234);
        chk("wr_a", 32'(sdr_a), 32'h1FFFF);
        chk("wr_rd", 32'(sdr_rd), 0);
        chk("wr_gnt", 32'(gnt), 32'b010);
        tick();
        tick();
        chk("wr_ack", 32'(ack), 32'b010);
        chk("wr_di1", 32'(di1), 0);
        chk("wr_di0", 32'(di0), 32'hBEEF);
        REQ = 3'b000;
        WE1 = 2'b00;
        tick();
        chk("wr_idle", 32'(busy), 0);

        // all three requesting, each re-asserts after its ACK
        do_reset();
        REQ = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] a;
            int n;
            n = 0;
            while (ack == 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk("arb_ack", 32'(ack), 32'(3'b001 << exp_ord[k]));
            chk("arb_gnt", 32'(gnt), 32'(3'b001 << exp_ord[k]));
            a = ack;
            REQ = REQ & ~a;
            tick();
            REQ = 3'b111;
        end
        REQ = 3'b000;

        // completion taken from SDR_WAIT
        do_reset();
        A0 = 17'h0ABCD;
        SDR_DI = 16'hC0DE;
        SDR_WAIT = 1'b1;
        REQ = 3'b001;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("wt_a", 32'(w_a), 32'h0ABCD);
            chk("wt_noack", 32'(w_ack), 0);
            tick();
        end
        chk("wt_cs", 32'(w_cs), 1);
        SDR_WAIT = 1'b0;
        tick();
        chk("wt_ack", 32'(w_ack), 32'b001);
        chk("wt_di0", 32'(w_di0), 32'hC0DE);
        REQ = 3'b000;

        // reset pulse mid-access
        do_reset();
        SDR_DI = 16'h7777;
        REQ = 3'b010;
        tick();
        chk("ra_cs_on", 32'(sdr_cs), 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ra_cs", 32'(sdr_cs), 0);
        chk("ra_gnt", 32'(gnt), 0);
        chk("ra_busy", 32'(busy), 0);
        tick();
        chk("ra_noack", 32'(ack), 0);
        RST_N = 1'b1;
        tick();
        chk("ra_regnt", 32'(gnt), 32'b010);
        tick();
        tick();
        chk("ra_ack", 32'(ack), 32'b010);
        chk("ra_di1", 32'(di1), 32'h7777);
        REQ = 3'b000;
        tick();

        // request withdrawn during access
        REQ = 3'b001;
        tick();
        REQ = 3'b000;
        tick();
        chk("dr_ack_early", 32'(ack), 0);
        tick();
        chk("dr_ack", 32'(ack), 32'b001);
        tick();
        chk("dr_ack_once", 32'(ack), 0);
        chk("dr_idle", 32'(busy), 0);
        tick();
        chk("dr_stay_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
